sdram_port: RTL and testbench

SDRAM_PORT -- requirements
Module: sdram_port

---
 rtl/sdram_port.sv | 110 +++++++++++
 tb/tb_sdram_port.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/sdram_port.sv
// sdram_port: posted-write queue plus read port in front of one toggle-handshake SDRAM channel,
// with store-to-load forwarding from queued writes and a post-reset drain of any in-flight transfer.
module sdram_port #(
   parameter int ADDR_BITS = 24,
   parameter int DEPTH     = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 wr_valid,
   output logic                 wr_ready,
   input  logic [ADDR_BITS-1:0] wr_addr,
   input  logic [15:0]          wr_data,
   input  logic                 rd_valid,
   output logic                 rd_ready,
   input  logic [ADDR_BITS-1:0] rd_addr,
   output logic [15:0]          rd_data,
   output logic                 rd_done,
   output logic                 ch_req,
   input  logic                 ch_ack,
   output logic                 ch_we,
   output logic [ADDR_BITS-1:0] ch_address,
   output logic [15:0]          ch_data_write,
   input  logic [15:0]          ch_data_read
);
   localparam int PW = $clog2(DEPTH);
   typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;
   state_t state, state_n;
   logic [ADDR_BITS-1:0] addr_q [DEPTH];
   logic [15:0] data_q [DEPTH];
   logic [PW-1:0] wp, rp;
   logic [PW:0] count;
   logic [ADDR_BITS-1:0] pend_addr;
   logic pending, is_rd, push, pop, rd_acc, issue, done, synced, hit;
   logic req_q = 1'b0;
   logic [15:0] fwd;
   assign ch_req   = req_q;
   assign synced   = ch_ack == req_q;
   assign wr_ready = count != (PW+1)'(DEPTH) && state != DRAIN;
   assign rd_ready = !pending && state != DRAIN;
   assign push     = wr_valid && wr_ready;
   assign rd_acc   = rd_valid && rd_ready;
   always_comb begin
      issue   = state == IDLE && (pending || count != '0);
      done    = state == BUSY && synced;
      pop     = done && !is_rd;
      state_n = issue ? BUSY : (done || (state == DRAIN && synced)) ? IDLE : state;
   end
   // Walk oldest to newest so the newest match wins; a same-cycle write is newer still.
   always_comb begin
      hit = 1'b0;
      fwd = '0;
      for (int i = 0; i < DEPTH; i++)
         if ((PW+1)'(i) < count && addr_q[rp + PW'(i)] == rd_addr) begin
            hit = 1'b1;
            fwd = data_q[rp + PW'(i)];
         end
      if (push && wr_addr == rd_addr) begin
         hit = 1'b1;
         fwd = wr_data;
      end
   end
   always_ff @(posedge clk)
      if (push) begin
         addr_q[wp] <= wr_addr;
         data_q[wp] <= wr_data;
      end
   // The request toggle survives reset so an outstanding transfer can still be matched by its ack.
   always_ff @(posedge clk)
      if (!reset && issue) req_q <= ~req_q;
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= synced ? IDLE : DRAIN;
         wp            <= '0;
         rp            <= '0;
         count         <= '0;
         pending       <= 1'b0;
         pend_addr     <= '0;
         is_rd         <= 1'b0;
         rd_done       <= 1'b0;
         rd_data       <= '0;
         ch_we         <= 1'b0;
         ch_address    <= '0;
         ch_data_write <= '0;
      end else begin
         state   <= state_n;
         rd_done <= 1'b0;
         if (push) wp <= wp + 1'b1;
         if (pop) rp <= rp + 1'b1;
         count <= count + (PW+1)'(push) - (PW+1)'(pop);
         if (rd_acc && hit) begin
            rd_data <= fwd;
            rd_done <= 1'b1;
         end else if (rd_acc) begin
            pending   <= 1'b1;
            pend_addr <= rd_addr;
         end
         if (done && is_rd) begin
            rd_data <= ch_data_read;
            rd_done <= 1'b1;
            pending <= 1'b0;
         end
         if (issue) begin
            is_rd         <= pending;
            ch_we         <= !pending;
            ch_address    <= pending ? pend_addr : addr_q[rp];
            ch_data_write <= pending ? ch_data_write : data_q[rp];
         end
      end
   end
endmodule

// File: tb/tb_sdram_port.sv
// tb_sdram_port: directed vectors and hand sequences for forwarding, queue full, read priority and reset drain.
module tb_sdram_port;
   logic clk = 1'b0, reset = 1'b1;
   logic wr_valid = 1'b0, rd_valid = 1'b0, ch_ack = 1'b0;
   logic [23:0] wr_addr = '0, rd_addr = '0;
   logic [15:0] wr_data = '0, ch_data_read = '0;
   logic wr_ready, rd_ready, rd_done, ch_req, ch_we;
   logic [15:0] rd_data, ch_data_write;
   logic [23:0] ch_address;
   int checks = 0, errors = 0;
   logic [15:0] mem [logic [23:0]];
   typedef struct packed {
      logic wv; logic [23:0] wa; logic [15:0] wd; logic rv; logic [23:0] ra;
      logic e_wrdy; logic e_rrdy; logic e_done; logic [15:0] e_data; logic e_req;
   } vec_t;
   vec_t v [9];

   sdram_port #(.ADDR_BITS(24), .DEPTH(4)) dut (
      .clk(clk), .reset(reset),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
      .rd_data(rd_data), .rd_done(rd_done),
      .ch_req(ch_req), .ch_ack(ch_ack), .ch_we(ch_we), .ch_address(ch_address),
      .ch_data_write(ch_data_write), .ch_data_read(ch_data_read));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Channel model: waits for an outstanding request, services it against mem, then acks.
   task automatic ack_one(input string tag);
      int n = 0;
      do begin @(negedge clk); n++; end while (ch_req == ch_ack && n < 20);
      if (ch_req == ch_ack) begin
         checks++;
         errors++;
         $display("FAIL %s: no channel request within 20 cycles", tag);
      end else begin
         if (ch_we) mem[ch_address] = ch_data_write;
         else ch_data_read = mem.exists(ch_address) ? mem[ch_address] : 16'hDEAD;
         ch_ack = ch_req;
      end
   endtask

   function automatic vec_t mk(input logic wv, input logic [23:0] wa, input logic [15:0] wd,
                               input logic rv, input logic [23:0] ra, input logic e_wrdy,
                               input logic e_rrdy, input logic e_done, input logic [15:0] e_data,
                               input logic e_req);
      return '{wv, wa, wd, rv, ra, e_wrdy, e_rrdy, e_done, e_data, e_req};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      mem[24'h50] = 16'h5A5A;
      // Channel never acks during the table, so the first write stays in flight and the queue fills.
      v[0] = mk(1'b1, 24'h20, 16'h1111, 1'b0, 24'h00, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
      v[1] = mk(1'b1, 24'h20, 16'h2222, 1'b0, 24'h00, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
      v[2] = mk(1'b0, 24'h00, 16'h0000, 1'b1, 24'h20, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
      v[3] = mk(1'b0, 24'h00, 16'h0000, 1'b0, 24'h00, 1'b1, 1'b1, 1'b1, 16'h2222, 1'b1);
      v[4] = mk(1'b1, 24'h30, 16'hABCD, 1'b1, 24'h30, 1'b1, 1'b1, 1'b0, 16'h2222, 1'b1);
      v[5] = mk(1'b1, 24'h40, 16'h4444, 1'b0, 24'h00, 1'b1, 1'b1, 1'b1, 16'hABCD, 1'b1);
      v[6] = mk(1'b1, 24'h50, 16'h5555, 1'b0, 24'h00, 1'b0, 1'b1, 1'b0, 16'hABCD, 1'b1);
      v[7] = mk(1'b0, 24'h00, 16'h0000, 1'b1, 24'h50, 1'b0, 1'b1, 1'b0, 16'hABCD, 1'b1);
      v[8] = mk(1'b0, 24'h00, 16'h0000, 1'b0, 24'h00, 1'b0, 1'b0, 1'b0, 16'hABCD, 1'b1);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk("rst_rd_done", rd_done, 1'b0);
      chk("rst_rd_data", rd_data, 16'h0);
      chk("rst_ch_we", ch_we, 1'b0);
      chk("rst_ch_address", ch_address, 24'h0);
      chk("rst_ch_data_write", ch_data_write, 16'h0);
      chk("rst_ch_req", ch_req, 1'b0);
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         chk($sformatf("v%0d_wr_ready", i), wr_ready, v[i].e_wrdy);
         chk($sformatf("v%0d_rd_ready", i), rd_ready, v[i].e_rrdy);
         chk($sformatf("v%0d_rd_done", i), rd_done, v[i].e_done);
         chk($sformatf("v%0d_rd_data", i), rd_data, v[i].e_data);
         chk($sformatf("v%0d_ch_req", i), ch_req, v[i].e_req);
         wr_valid = v[i].wv; wr_addr = v[i].wa; wr_data = v[i].wd;
         rd_valid = v[i].rv; rd_addr = v[i].ra;
      end
      // Head write still in flight; pending read 0x50 must go before the remaining queued writes.
      chk("inflight_we", ch_we, 1'b1);
      chk("inflight_addr", ch_address, 24'h20);
      chk("inflight_data", ch_data_write, 16'h1111);
      ack_one("ack_head");
      @(negedge clk);
      chk("after_ack_wr_ready", wr_ready, 1'b1);
      @(negedge clk);
      chk("prio_read_we", ch_we, 1'b0);
      chk("prio_read_addr", ch_address, 24'h50);
      chk("prio_read_busy", ch_req ^ ch_ack, 1'b1);
      ack_one("ack_read50");
      @(negedge clk);
      chk("read50_done", rd_done, 1'b1);
      chk("read50_data", rd_data, 16'h5A5A);
      @(negedge clk);
      chk("next_write_we", ch_we, 1'b1);
      chk("next_write_addr", ch_address, 24'h20);
      chk("next_write_data", ch_data_write, 16'h2222);
      chk("next_write_no_done", rd_done, 1'b0);
      repeat (3) ack_one("ack_queue");
      repeat (3) @(negedge clk);
      chk("queue_empty_idle", ch_req ^ ch_ack, 1'b0);
      chk("mem_0x30", mem.exists(24'h30) ? mem[24'h30] : 16'h0, 16'hABCD);
      // Write, let it complete, then read the same address back through the channel.
      wr_valid = 1'b1; wr_addr = 24'h10; wr_data = 16'hF7F8;
      @(negedge clk);
      wr_valid = 1'b0;
      ack_one("ack_w10");
      repeat (2) @(negedge clk);
      rd_valid = 1'b1; rd_addr = 24'h10;
      @(negedge clk);
      rd_valid = 1'b0;
      chk("r10_rd_ready_pending", rd_ready, 1'b0);
      ack_one("ack_r10");
      chk("r10_we", ch_we, 1'b0);
      chk("r10_addr", ch_address, 24'h10);
      @(negedge clk);
      chk("r10_done", rd_done, 1'b1);
      chk("r10_data", rd_data, 16'hF7F8);
      @(negedge clk);
      chk("r10_done_pulse", rd_done, 1'b0);
      chk("r10_data_hold", rd_data, 16'hF7F8);
      // Reset while a channel read is outstanding, with a write queued behind it.
      wr_valid = 1'b1; wr_addr = 24'h77; wr_data = 16'h7777;
      rd_valid = 1'b1; rd_addr = 24'h99;
      @(negedge clk);
      wr_valid = 1'b0; rd_valid = 1'b0;
      @(negedge clk);
      chk("r99_we", ch_we, 1'b0);
      chk("r99_addr", ch_address, 24'h99);
      chk("r99_busy", ch_req ^ ch_ack, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("drain_rd_ready", rd_ready, 1'b0);
      chk("drain_wr_ready", wr_ready, 1'b0);
      chk("drain_addr_cleared", ch_address, 24'h0);
      chk("drain_no_done0", rd_done, 1'b0);
      @(negedge clk);
      chk("drain_rd_ready_hold", rd_ready, 1'b0);
      ch_data_read = 16'hBEEF;
      ch_ack = ch_req;
      @(negedge clk);
      chk("drain_no_done1", rd_done, 1'b0);
      chk("drain_rd_data", rd_data, 16'h0);
      chk("post_drain_rd_ready", rd_ready, 1'b1);
      chk("post_drain_wr_ready", wr_ready, 1'b1);
      repeat (2) @(negedge clk);
      chk("post_drain_no_issue", ch_req ^ ch_ack, 1'b0);
      chk("post_drain_no_done", rd_done, 1'b0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
